layer_output_collector: RTL and testbench
=========================================

Name: layer_output_collector

Overview:
- Sits directly upstream of the argmax stage.
- Gathers the per-neuron outputs of the final layer into one packed vector. Neurons may complete on different cycles, each raising its own valid bit.
- Once every neuron has reported, it emits the full vector with a one-cycle valid pulse, which is the argmax stage's i_valid/i_data.
- Also counts completed frames and flags protocol overruns.

Parameters:
- numNeuron, 10, number of neurons (slots) in the output layer; 2..16.
- dataWidth, 16, width of each neuron output in bits.

Ports:
- i_clk  input  1  clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_data  input  numNeuron*dataWidth  neuron outputs; slot k is bits [k*dataWidth +: dataWidth].
- i_valid  input  numNeuron  bit k high for one cycle means slot k of i_data is valid that cycle.
- i_clr_err  input  1  synchronous clear of o_overrun.
- o_data  output  numNeuron*dataWidth  last completed packed vector, same slot layout as i_data.
- o_data_valid  output  1  one-cycle pulse when o_data has been updated with a new complete vector.
- o_overrun  output  1  sticky error: a slot was written twice within one frame.
- o_frame_count  output  16  number of completed frames, wraps 0xFFFF->0x0000.

Behaviour:
- Reset (async, active-high): all of the following are zero.
  - Internal capture buffer and captured mask.
  - o_data, o_data_valid, o_overrun, o_frame_count.
- Reset asserted mid-frame discards the partial frame; no pulse is produced.
- Capture, per rising edge, for each k with i_valid[k]=1:
  - The buffer slot k is loaded from i_data slot k.
  - mask[k] is set to 1.
  - Slots with i_valid[k]=0 hold their value.
- Completion condition: (mask | i_valid) == all ones at a clock edge. On that edge:
  - o_data is loaded with the merged vector: the new i_data for the slots valid this cycle, and the buffer contents for all other slots.
  - mask is cleared to 0.
  - o_data_valid is 1 for exactly the following cycle.
  - o_frame_count increments.
- Latency: o_data_valid is high in the cycle after the last missing slot's valid. If all numNeuron valids are high together, the pulse follows that cycle directly.
- o_data holds its value between completions; it is never altered by partial captures.
- o_data_valid is 0 in every cycle not directly following a completion edge. Back-to-back completions give consecutive pulses.
- Overrun: i_valid[k]=1 while mask[k]=1 (before completion) causes:
  - o_overrun is set to 1.
  - The slot is overwritten (last value wins).
  - The frame is not aborted.
- Overrun and completion on the same edge: both take effect. The merged vector uses the newest value.
- After a completion edge, mask is 0. Valids on the next cycle start a new frame and never cause an overrun.
- i_clr_err=1: o_overrun is cleared at that edge. If an overrun event occurs on the same edge, set wins.
- Arithmetic: pure data movement, no width conversion. The frame counter is a 16-bit modulo-2^16 increment.

Test Plan:
1. All valids together: after reset, i_valid=10'h3FF with slot k = k+1 for one cycle.
   - Next cycle: o_data_valid=1 and o_data slots = 1..10.
   - o_frame_count=1 and o_overrun=0.
2. Staggered arrival: valids for slots 0..9 on ten separate cycles, slot k value 0x0100+k.
   - No pulse occurs until the cycle after slot 9.
   - o_data then matches all ten values, and o_data holds unchanged for 20 idle cycles.
3. Overrun: slot 3 written with 0x1111, then 0x2222, then remaining slots complete the frame.
   - o_overrun=1 and o_data slot 3 = 0x2222.
   - Assert i_clr_err for one cycle, then o_overrun=0.
4. Reset mid-frame: write slots 0..4, assert reset for one cycle, then write slots 5..9.
   - No pulse occurs.
   - Writing all 10 slots afterwards gives exactly one pulse, and o_frame_count=1.
5. Back-to-back frames: i_valid=10'h3FF on two consecutive cycles with different data.
   - Two consecutive o_data_valid pulses, each with its own vector.
   - o_frame_count=2 and o_overrun=0.
6. Counter wrap: run 65536 full frames.
   - o_frame_count returns to 0x0000, and each frame still pulses once.

Source files
------------

// File: rtl/layer_output_collector.sv
// Collects per-neuron outputs of the final layer into one packed vector.
// Emits a one-cycle valid pulse once every slot has reported in the current frame.
module layer_output_collector #(
    parameter int numNeuron = 10,
    parameter int dataWidth = 16
) (
    input  logic                             i_clk,
    input  logic                             reset,
    input  logic [numNeuron*dataWidth-1:0]   i_data,
    input  logic [numNeuron-1:0]             i_valid,
    input  logic                             i_clr_err,
    output logic [numNeuron*dataWidth-1:0]   o_data,
    output logic                             o_data_valid,
    output logic                             o_overrun,
    output logic [15:0]                      o_frame_count
);

    localparam int VEC_W = numNeuron * dataWidth;

    logic [VEC_W-1:0]     buf_r;
    logic [numNeuron-1:0] mask_r;
    logic [VEC_W-1:0]     merged_s;
    logic [numNeuron-1:0] mask_next_s;
    logic                 complete_s;
    logic                 overrun_evt_s;

    // Merge this cycle's valid slots over the buffered ones.
    always_comb begin
        merged_s = buf_r;
        for (int k = 0; k < numNeuron; k++) begin
            if (i_valid[k]) begin
                merged_s[k*dataWidth +: dataWidth] = i_data[k*dataWidth +: dataWidth];
            end else begin
                merged_s[k*dataWidth +: dataWidth] = buf_r[k*dataWidth +: dataWidth];
            end
        end
    end

    // Frame completion, overrun detection and next captured mask.
    always_comb begin
        complete_s    = &(mask_r | i_valid);
        overrun_evt_s = |(mask_r & i_valid);
        if (complete_s) begin
            mask_next_s = {numNeuron{1'b0}};
        end else begin
            mask_next_s = mask_r | i_valid;
        end
    end

    // Capture buffer and mask; buffer contents are don't-care once the mask clears.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            buf_r  <= {VEC_W{1'b0}};
            mask_r <= {numNeuron{1'b0}};
        end else begin
            buf_r  <= merged_s;
            mask_r <= mask_next_s;
        end
    end

    // Registered outputs: vector, pulse and frame counter.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            o_data        <= {VEC_W{1'b0}};
            o_data_valid  <= 1'b0;
            o_frame_count <= 16'h0000;
        end else begin
            o_data_valid <= complete_s;
            if (complete_s) begin
                o_data        <= merged_s;
                o_frame_count <= o_frame_count + 16'd1;
            end else begin
                o_data        <= o_data;
                o_frame_count <= o_frame_count;
            end
        end
    end

    // Sticky overrun flag; a new event beats a simultaneous clear.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            o_overrun <= 1'b0;
        end else if (overrun_evt_s) begin
            o_overrun <= 1'b1;
        end else if (i_clr_err) begin
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= o_overrun;
        end
    end

endmodule

// File: tb/tb_layer_output_collector.sv
// Randomized + directed bench for layer_output_collector with a queue-based scoreboard.
// The reference model tracks slot values and a seen-set per frame.
module tb_layer_output_collector;

    localparam int N  = 10;
    localparam int W  = 16;
    localparam int VW = N * W;

    logic          i_clk;
    logic          reset;
    logic [VW-1:0] i_data;
    logic [N-1:0]  i_valid;
    logic          i_clr_err;
    logic [VW-1:0] o_data;
    logic          o_data_valid;
    logic          o_overrun;
    logic [15:0]   o_frame_count;

    layer_output_collector #(.numNeuron(N), .dataWidth(W)) dut (
        .i_clk         (i_clk),
        .reset         (reset),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .i_clr_err     (i_clr_err),
        .o_data        (o_data),
        .o_data_valid  (o_data_valid),
        .o_overrun     (o_overrun),
        .o_frame_count (o_frame_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [VW-1:0] data;
        logic [15:0]   cnt;
        logic          ovr;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;

    // Reference model state
    logic [W-1:0]  m_val[N];
    bit            m_seen[N];
    logic [15:0]   m_cnt;
    bit            m_ovr;
    logic [VW-1:0] hold_data;

    function automatic void chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < N; k++) begin
            m_val[k]  = '0;
            m_seen[k] = 1'b0;
        end
        m_cnt = 16'h0000;
        m_ovr = 1'b0;
    endfunction

    function automatic void model_step(input logic [N-1:0] v, input logic [VW-1:0] d, input logic clr);
        bit   evt = 1'b0;
        bit   all = 1'b1;
        exp_t e;
        for (int k = 0; k < N; k++) begin
            if (v[k]) begin
                if (m_seen[k]) evt = 1'b1;
                m_val[k]  = d[k*W +: W];
                m_seen[k] = 1'b1;
            end
        end
        if (evt) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        for (int k = 0; k < N; k++) if (!m_seen[k]) all = 1'b0;
        if (all) begin
            m_cnt = m_cnt + 16'd1;
            for (int k = 0; k < N; k++) begin
                e.data[k*W +: W] = m_val[k];
                m_seen[k] = 1'b0;
            end
            e.cnt = m_cnt;
            e.ovr = m_ovr;
            exp_q.push_back(e);
        end
    endfunction

    // Monitor: pops an expectation on each pulse, otherwise checks o_data holds.
    always @(negedge i_clk) begin
        exp_t e;
        if (o_data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual=1 expected=0 t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_data", o_data, e.data);
                chk("pulse_count", {{(VW-16){1'b0}}, o_frame_count}, {{(VW-16){1'b0}}, e.cnt});
                chk("pulse_overrun", {{(VW-1){1'b0}}, o_overrun}, {{(VW-1){1'b0}}, e.ovr});
                hold_data = e.data;
            end
        end else begin
            chk("hold_data", o_data, hold_data);
        end
    end

    task automatic cyc(input logic [N-1:0] v, input logic [VW-1:0] d, input logic clr);
        i_valid   = v;
        i_data    = d;
        i_clr_err = clr;
        model_step(v, d, clr);
        @(posedge i_clk);
        #1;
        i_valid   = '0;
        i_clr_err = 1'b0;
        chk("overrun", {{(VW-1){1'b0}}, o_overrun}, {{(VW-1){1'b0}}, m_ovr});
        chk("frame_count", {{(VW-16){1'b0}}, o_frame_count}, {{(VW-16){1'b0}}, m_cnt});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, '0, 1'b0);
    endtask

    task automatic do_reset();
        idle(1);
        reset = 1'b1;
        model_clear();
        hold_data = '0;
        @(posedge i_clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'($urandom);
        return r;
    endfunction

    function automatic logic [VW-1:0] one_slot(input int k, input logic [W-1:0] val);
        logic [VW-1:0] r = '0;
        r[k*W +: W] = val;
        return r;
    endfunction

    initial begin
        logic [VW-1:0] d;
        logic [N-1:0]  v;
        logic [N-1:0]  all_v = {N{1'b1}};
        reset     = 1'b1;
        i_valid   = '0;
        i_data    = '0;
        i_clr_err = 1'b0;
        model_clear();
        hold_data = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_data", o_data, '0);
        chk("reset_valid", {{(VW-1){1'b0}}, o_data_valid}, '0);
        chk("reset_overrun", {{(VW-1){1'b0}}, o_overrun}, '0);
        chk("reset_count", {{(VW-16){1'b0}}, o_frame_count}, '0);
        reset = 1'b0;

        // 1: all valids together
        for (int k = 0; k < N; k++) d[k*W +: W] = W'(k + 1);
        cyc(all_v, d, 1'b0);
        idle(2);

        // 2: staggered arrival then hold
        for (int k = 0; k < N; k++) cyc(N'(1) << k, one_slot(k, W'(16'h0100 + k)), 1'b0);
        idle(20);

        // 3: overrun on slot 3, then clear
        cyc(N'(1) << 3, one_slot(3, 16'h1111), 1'b0);
        cyc(N'(1) << 3, one_slot(3, 16'h2222), 1'b0);
        cyc(all_v & ~(N'(1) << 3), rand_vec(), 1'b0);
        idle(2);
        cyc('0, '0, 1'b1);
        idle(2);

        // 4: reset mid-frame
        do_reset();
        for (int k = 0; k < 5; k++) cyc(N'(1) << k, one_slot(k, W'($urandom)), 1'b0);
        do_reset();
        for (int k = 5; k < N; k++) cyc(N'(1) << k, one_slot(k, W'($urandom)), 1'b0);
        idle(3);
        do_reset();
        cyc(all_v, rand_vec(), 1'b0);
        idle(2);

        // 5: back-to-back frames
        do_reset();
        cyc(all_v, rand_vec(), 1'b0);
        cyc(all_v, rand_vec(), 1'b0);
        idle(2);

        // Random traffic with natural overruns and occasional clears
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < N; k++) v[k] = ($urandom_range(0, 9) < 3);
            cyc(v, rand_vec(), ($urandom_range(0, 19) == 0));
        end
        idle(2);

        // 6: counter wrap after 65536 full frames
        do_reset();
        for (int i = 0; i < 65536; i++) cyc(all_v, rand_vec(), 1'b0);
        idle(2);
        chk("wrap_count", {{(VW-16){1'b0}}, o_frame_count}, '0);
        chk("queue_empty", VW'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
